copy_tag_stage: RTL

COPY_TAG_STAGE -- requirements
Module: copy_tag_stage

---
 rtl/copy_tag_stage_if.sv | 20 ++
 rtl/copy_tag_stage.sv | 61 ++++++
 2 files changed

// File: rtl/copy_tag_stage_if.sv
// copy_tag_stage_if: packet handshake and copy-attribute table write port
interface copy_tag_stage_if;
  logic        Send_in;
  logic        Ack_out;
  logic [37:0] PACKET_IN;
  logic        Send_out;
  logic        Ack_in;
  logic [39:0] PACKET_OUT;
  logic        TBL_WE;
  logic [6:0]  TBL_ADDR;
  logic [2:0]  TBL_DATA;
  modport master (
    output Send_in, PACKET_IN, Ack_in, TBL_WE, TBL_ADDR, TBL_DATA,
    input  Ack_out, Send_out, PACKET_OUT
  );
  modport slave (
    input  Send_in, PACKET_IN, Ack_in, TBL_WE, TBL_ADDR, TBL_DATA,
    output Ack_out, Send_out, PACKET_OUT
  );
endinterface

// File: rtl/copy_tag_stage.sv
// copy_tag_stage: tags packets from a 128x3 copy table into a 2-deep FIFO; COPY_TAG_STATS_EN adds transfer counters
module copy_tag_stage (
  input logic CLK,
  input logic MR,
  copy_tag_stage_if.slave bus
`ifdef COPY_TAG_STATS_EN
  ,
  output logic [15:0] STAT_PKTS,
  output logic [15:0] STAT_CPY
`endif
);
  logic [2:0]  tbl [128];
  logic [39:0] mem [2];
  logic        wp, rp, push, pop, full, empty, unused_lr_arrival;
  logic [1:0]  cnt;
  logic [2:0]  ent;
  logic [6:0]  dest;
  logic [39:0] pkt;
  always_comb begin
    dest  = bus.PACKET_IN[26:20];
    ent   = tbl[dest];
    pkt   = {bus.PACKET_IN[37:27], dest, ent[1], ent[0], bus.PACKET_IN[18],
             ent[2] & (dest != 7'h7F), bus.PACKET_IN[17:0]};
    full  = cnt == 2'd2;
    empty = cnt == 2'd0;
    push  = bus.Send_in & ~full;
    pop   = ~empty & bus.Ack_in;
  end
  assign unused_lr_arrival = bus.PACKET_IN[19];
  assign bus.Ack_out    = ~full;
  assign bus.Send_out   = ~empty;
  assign bus.PACKET_OUT = empty ? 40'b0 : mem[rp];
  // the table is read combinationally above, so a same-cycle write lands after the lookup
  always_ff @(posedge CLK)
    if (MR)
      for (int i = 0; i < 128; i++) tbl[i] <= 3'b000;
    else if (bus.TBL_WE)
      tbl[bus.TBL_ADDR] <= bus.TBL_DATA;
  always_ff @(posedge CLK)
    if (!MR && push) mem[wp] <= pkt;
  always_ff @(posedge CLK)
    if (MR) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      wp  <= wp ^ push;
      rp  <= rp ^ pop;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
`ifdef COPY_TAG_STATS_EN
  always_ff @(posedge CLK)
    if (MR) begin
      STAT_PKTS <= 16'd0;
      STAT_CPY  <= 16'd0;
    end else if (pop) begin
      STAT_PKTS <= STAT_PKTS == 16'hFFFF ? STAT_PKTS : STAT_PKTS + 16'd1;
      STAT_CPY  <= (mem[rp][18] && STAT_CPY != 16'hFFFF) ? STAT_CPY + 16'd1 : STAT_CPY;
    end
`endif
endmodule
